// File: rtl/uart_rx.sv
// 8N1 UART receiver with a synchronised input, mid-bit sampling and a read buffer.
// Build option UART_RX_FIFO_EN: FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  input  logic       rd_en,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  logic        sync1_q, rx_s_q, rx_prev_q;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        push, frame_set, pop, full, accept, overrun_set;
  logic        frame_err_q, frame_err_d, overrun_q, overrun_d;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_pin;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // NOTE: every output of this block is given a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      // An edge needs rx_s high the cycle before, so a held break cannot re-arm.
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) push = 1'b1;
          else        frame_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees a full slot in the same cycle, so push-and-pop while full is not an overrun.
  assign pop         = rd_en && rx_avail;
  assign accept      = push && (!full || pop);
  assign overrun_set = push && full && !pop;

`ifdef UART_RX_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  assign full = (count_q == CNT_FULL);

  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (accept && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !accept) count_d = count_q - CNT_ONE;
  end

  // NOTE: the storage is reset because it is a handful of flops and rx_data must
  // read 8'h00 straight out of reset; a large RAM-backed FIFO would not do this.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) mem_q[wr_ptr_q] <= shift_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rx_data  = mem_q[rd_ptr_q];
  assign rx_avail = (count_q != '0);
`else
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  assign full = valid_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (pop) valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_avail = valid_q;
`endif

  // Set beats clear when both land in the same cycle.
  assign frame_err_d = frame_set   || (frame_err_q && !err_clr);
  assign overrun_d   = overrun_set || (overrun_q   && !err_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16; covers both buffer builds.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_avail, frame_err, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .rd_en(rd_en), .err_clr(err_clr),
    .rx_data(rx_data), .rx_avail(rx_avail), .frame_err(frame_err), .overrun(overrun)
  );

  // Starts on a falling clock edge; the stop bit lasts stop_cycles. pop_at >= 0 raises
  // rd_en for one cycle at that offset into the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int stop_cycles, input int pop_at);
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_pin = stop_bit;
    for (int i = 0; i < stop_cycles; i++) begin
      if (pop_at >= 0) rd_en = (i == pop_at);
      @(negedge clk);
    end
    if (pop_at >= 0) rd_en = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL reset_avail: got %b want 0", rx_avail); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    pulse_rd();
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL empty_pop: got avail %b want 0", rx_avail); end
  endtask

  task automatic test_single_frame();
    send_frame(8'h48, 1'b1, 4, -1);
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL single_early: got avail %b want 0", rx_avail); end
    repeat (12) @(negedge clk);
    n_cmp++; if (rx_avail !== 1'b1) begin n_bad++; $display("FAIL single_avail: got %b want 1", rx_avail); end
    n_cmp++; if (rx_data !== 8'h48) begin n_bad++; $display("FAIL single_data: got %h want 48", rx_data); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL single_ferr: got %b want 0", frame_err); end
    pulse_rd();
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL single_pop: got avail %b want 0", rx_avail); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h48, 1'b1, CPB, -1);
    fork
      send_frame(8'h69, 1'b1, CPB, -1);
      begin
        n_cmp++; if (rx_data !== 8'h48) begin n_bad++; $display("FAIL b2b_first: got %h want 48", rx_data); end
        pulse_rd();
        n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL b2b_pop1: got avail %b want 0", rx_avail); end
      end
    join
    n_cmp++; if (rx_avail !== 1'b1) begin n_bad++; $display("FAIL b2b_avail2: got %b want 1", rx_avail); end
    n_cmp++; if (rx_data !== 8'h69) begin n_bad++; $display("FAIL b2b_second: got %h want 69", rx_data); end
    pulse_rd();
    n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_bad++; $display("FAIL b2b_flags: got %b want 00", {frame_err, overrun}); end
  endtask

  task automatic test_glitch();
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL glitch_avail: got %b want 0", rx_avail); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL glitch_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_frame_error();
    send_frame(8'hA5, 1'b0, CPB, -1);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL ferr_nopush: got avail %b want 0", rx_avail); end
    pulse_clr();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clr: got %b want 0", frame_err); end
    // Line held low as a break: must not start another frame.
    repeat (200) @(negedge clk);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL break_retrig: got ferr %b want 0", frame_err); end
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL break_avail: got %b want 0", rx_avail); end
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_overrun();
`ifdef UART_RX_FIFO_EN
    logic [7:0] exp_b [5];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_frame(exp_b[i], 1'b1, CPB, -1);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx_data !== exp_b[i]) begin n_bad++; $display("FAIL ovr_fifo_data%0d: got %h want %h", i, rx_data, exp_b[i]); end
      pulse_rd();
    end
`else
    send_frame(8'h11, 1'b1, CPB, -1);
    send_frame(8'h22, 1'b1, CPB, -1);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
    n_cmp++; if (rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_keep: got %h want 11", rx_data); end
    pulse_rd();
`endif
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL ovr_drain: got avail %b want 0", rx_avail); end
    pulse_clr();
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b want 0", overrun); end
  endtask

  task automatic test_push_pop_full();
`ifdef UART_RX_FIFO_EN
    logic [7:0] exp_b [5];
    exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1, CPB, -1);
    // Offset 10 into the stop bit lines rd_en up with the push edge.
    send_frame(exp_b[4], 1'b1, CPB, 10);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL pp_ovr: got %b want 0", overrun); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (rx_data !== exp_b[i]) begin n_bad++; $display("FAIL pp_fifo_data%0d: got %h want %h", i, rx_data, exp_b[i]); end
      pulse_rd();
    end
`else
    send_frame(8'h77, 1'b1, CPB, -1);
    send_frame(8'h88, 1'b1, CPB, 10);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL pp_ovr: got %b want 0", overrun); end
    n_cmp++; if (rx_avail !== 1'b1) begin n_bad++; $display("FAIL pp_avail: got %b want 1", rx_avail); end
    n_cmp++; if (rx_data !== 8'h88) begin n_bad++; $display("FAIL pp_data: got %h want 88", rx_data); end
    pulse_rd();
`endif
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL pp_drain: got avail %b want 0", rx_avail); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h5A;
    send_frame(8'hA5, 1'b0, CPB, -1);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h3C, 1'b1, CPB, -1);
    n_cmp++; if ({rx_avail, frame_err} !== 2'b11) begin n_bad++; $display("FAIL mid_pre: got avail/ferr %b want 11", {rx_avail, frame_err}); end
    rx_pin = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_pin = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_pin = b[3];
    repeat (CPB / 2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_avail !== 1'b0) begin n_bad++; $display("FAIL mid_rst_avail: got %b want 0", rx_avail); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ferr: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ovr: got %b want 0", overrun); end
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'hC3, 1'b1, CPB, -1);
    n_cmp++; if (rx_avail !== 1'b1) begin n_bad++; $display("FAIL mid_after_avail: got %b want 1", rx_avail); end
    n_cmp++; if (rx_data !== 8'hC3) begin n_bad++; $display("FAIL mid_after_data: got %h want C3", rx_data); end
    n_cmp++; if ({frame_err, overrun} !== 2'b00) begin n_bad++; $display("FAIL mid_after_flags: got %b want 00", {frame_err, overrun}); end
    pulse_rd();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive peripheral for the MCU: the receive-side counterpart of the UART transmitter that drives the MCU's transmit pin.
- Deserialises 8N1 frames arriving on an input pin and buffers the received bytes.
- Presents bytes to the MCU bus-side logic through a simple available/read handshake, with sticky frame-error and overrun flags.
- Baud timing matches the transmitter: one bit period is CLKS_PER_BIT system clocks.

Parameters:
- CLKS_PER_BIT, 868, system clocks per bit (100 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 4, receive FIFO entries (power of two, 2..16); used only when UART_RX_FIFO_EN is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx_pin  input  1  serial line; asynchronous to clk; idles high.
- rd_en  input  1  pop the current byte; honoured only while rx_avail=1.
- err_clr  input  1  clears frame_err and overrun for one cycle.
- rx_data  output  8  oldest unread byte; value undefined-but-stable while rx_avail=0.
- rx_avail  output  1  at least one unread byte is buffered.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte arrived while the buffer was full.

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_data=8'h00, rx_avail=0, frame_err=0, overrun=0.
  - Buffer empty; FSM in IDLE; synchroniser flops set to 1.
- Input conditioning:
  - rx_pin passes through a 2-flop synchroniser; the FSM sees only the synchronised value rx_s.
  - A start edge is a 1->0 transition of rx_s.
- FSM states: IDLE, START, DATA, STOP. A single baud counter and a 3-bit bit index are used throughout.
  - IDLE: on a falling edge of rx_s, clear the counter and go to START.
  - START: count (CLKS_PER_BIT/2)-1 cycles, then sample rx_s.
    - rx_s=1: false start, return to IDLE.
    - rx_s=0: clear the counter and bit index, go to DATA.
  - DATA: count CLKS_PER_BIT cycles, then sample rx_s into the shift register, LSB first.
    - After bit 7 is sampled, go to STOP.
  - STOP: count CLKS_PER_BIT cycles, then sample rx_s and return to IDLE.
    - rx_s=1: push the byte into the buffer.
    - rx_s=0: discard the byte and set frame_err.
    - When rx_s=0, IDLE does not arm again until rx_s has been seen high for at least one cycle (a break condition must not retrigger).
- Latency: the pushed byte is visible on rx_data, with rx_avail=1, on the clock edge after the stop-bit sample.
- Buffer: a single holding register (see Optional Feature).
  - Push while full: the byte is dropped, the buffered content is unchanged, and overrun is set.
  - rd_en=1 with rx_avail=1: pop; the next byte (or empty) is shown on the following edge.
  - rd_en=1 with rx_avail=0: ignored; no state change.
  - Push and pop in the same cycle while full: both take effect and overrun stays unchanged.
  - Push and pop in the same cycle while holding one entry: the new byte is shown and rx_avail stays 1.
- Flags:
  - err_clr clears both flags.
  - If a set event and err_clr occur in the same cycle, set wins.
  - Flags never affect reception.
- Reset mid-frame: the partial byte is lost and the buffer is emptied. After rst is released, the receiver waits for a fresh falling edge; mid-frame low data bits may be picked up as starts and resolve as frame errors.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined:
  - The buffer is a FIFO of FIFO_DEPTH entries with read/write pointers and a count.
  - rx_data shows the head entry.
  - Full means count==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Undefined:
  - The buffer is one holding register (depth 1).
  - FIFO_DEPTH is ignored.
- All other behaviour is identical in both builds.

Test Plan:
- Single frame: with CLKS_PER_BIT=16, drive 8'h48 (0x48) 8N1 -> rx_avail=1 one cycle after the stop sample, rx_data=8'h48; rd_en pulse -> rx_avail=0.
- Back-to-back frames: drive 8'h48 then 8'h69 with no idle gap, popping each on arrival -> both bytes read in order; frame_err=0, overrun=0.
- Glitch and framing:
  - A 3-cycle low glitch on rx_pin -> no byte, FSM returns to IDLE.
  - Frame 8'hA5 with the stop bit low -> frame_err=1 and nothing pushed.
  - err_clr -> frame_err=0.
- Overrun: send 8'h11 and 8'h22 without popping (holding-register build) -> rx_data=8'h11, overrun=1. With UART_RX_FIFO_EN and depth 4, five frames with no reads -> the first four are read back in order and overrun=1.
- Reset mid-frame: assert rst at data bit 3 of 8'h5A -> all outputs return to reset values immediately; after release, a clean 8'hC3 frame is received correctly.
- Simultaneous pop and push while full: rd_en coincides with the push edge -> no overrun, and the new byte is readable next.
